// File: rtl/fsm_ctx_scheduler.sv
`default_nettype none
// ============================================================================
// fsm_ctx_scheduler : one 4-state Mealy engine shared by NCH bit streams via round-robin.
// Optional per-channel Z=1 hit counters: FSM_SCHED_STATS_EN.   Rev 1.0
// ============================================================================
module fsm_ctx_scheduler #(
  parameter int NCH   = 4,
  parameter int CHW   = $clog2(NCH),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   in_valid,
  input  logic [NCH-1:0]   in_bit,
  output logic [NCH-1:0]   in_ready,
  input  logic [NCH-1:0]   ctx_clear,
  output logic             out_valid,
  output logic             out_z,
  output logic [CHW-1:0]   out_ch,
  input  logic             out_ready,
  input  logic [CHW-1:0]   stat_sel,
  output logic [CNT_W-1:0] stat_cnt
);

  typedef enum logic [1:0] {
    ST_A = 2'b00,
    ST_B = 2'b01,
    ST_E = 2'b10,
    ST_F = 2'b11
  } state_e;

  state_e         ctx_q [NCH];
  logic [CHW-1:0] rr_ptr_q, rr_ptr_d;
  logic           out_valid_q, out_valid_d;
  logic           out_z_q, out_z_d;
  logic [CHW-1:0] out_ch_q, out_ch_d;

  logic           stall;
  logic [NCH-1:0] eligible;
  logic           grant_vld;
  logic [CHW-1:0] grant_ch;
  state_e         cur_st, nxt_st;
  logic           nxt_z;

  assign stall    = out_valid_q & ~out_ready;
  assign eligible = in_valid & ~ctx_clear;

  // First eligible channel at or after rr_ptr, wrapping at NCH-1.
  always_comb begin : arbiter
    logic [CHW:0] idx;
    grant_vld = 1'b0;
    grant_ch  = '0;
    idx       = '0;
    if (!stall) begin
      for (int k = 0; k < NCH; k++) begin
        idx = {1'b0, rr_ptr_q} + (CHW+1)'(k);
        if (idx >= (CHW+1)'(NCH)) idx = idx - (CHW+1)'(NCH);
        if (!grant_vld && eligible[idx[CHW-1:0]]) begin
          grant_vld = 1'b1;
          grant_ch  = idx[CHW-1:0];
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (grant_vld) in_ready[grant_ch] = 1'b1;
  end

  always_comb begin
    cur_st = ctx_q[grant_ch];
    nxt_st = ST_A;
    nxt_z  = 1'b0;
    case (cur_st)
      ST_A: begin nxt_st = in_bit[grant_ch] ? ST_B : ST_E; nxt_z = in_bit[grant_ch]; end
      ST_B: begin nxt_st = in_bit[grant_ch] ? ST_B : ST_F; end
      ST_E: begin nxt_st = in_bit[grant_ch] ? ST_F : ST_A; nxt_z = in_bit[grant_ch]; end
      ST_F: begin nxt_st = in_bit[grant_ch] ? ST_A : ST_B; end
      default: begin nxt_st = ST_A; nxt_z = 1'b0; end
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_z_d     = out_z_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (grant_vld) begin
      out_valid_d = 1'b1;
      out_z_d     = nxt_z;
      out_ch_d    = grant_ch;
      rr_ptr_d    = (grant_ch == CHW'(NCH-1)) ? '0 : grant_ch + CHW'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_z_q     <= 1'b0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_z_q     <= out_z_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // Clear masks the channel from arbitration, so it never collides with a write-back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) ctx_q[i] <= ST_A;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ctx_clear[i])                             ctx_q[i] <= ST_A;
        else if (grant_vld && grant_ch == CHW'(i))    ctx_q[i] <= nxt_st;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_z     = out_z_q;
  assign out_ch    = out_ch_q;

`ifdef FSM_SCHED_STATS_EN
  logic [CNT_W-1:0] cnt_q [NCH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ctx_clear[i])
          cnt_q[i] <= '0;
        else if (grant_vld && grant_ch == CHW'(i) && nxt_z && (cnt_q[i] != '1))
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign stat_cnt = ({1'b0, stat_sel} < (CHW+1)'(NCH)) ? cnt_q[stat_sel] : '0;
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_cnt        = '0;
`endif

endmodule
`default_nettype wire

// File: doc/fsm_ctx_scheduler.md
Name: fsm_ctx_scheduler

Overview:
Time-multiplexes one 4-state Mealy sequence engine across NCH independent serial bit streams.
- A round-robin arbiter grants one requester per cycle.
- The scheduler loads that channel's saved state, evaluates the transition, registers the Z result and writes the next state back.
- It sits between the per-lane bit sources and the downstream event collector, replacing NCH separate engine instances.

Parameters:
- NCH, 4, number of channels (2..16).
- CHW, $clog2(NCH), channel index width (derived; do not override).
- CNT_W, 16, width of the per-channel hit counters (optional feature only).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  NCH  per-channel bit request.
- in_bit  in  NCH  per-channel input bit x.
- in_ready  out  NCH  one-hot grant (combinational); a transfer occurs when in_valid[i] & in_ready[i].
- ctx_clear  in  NCH  synchronous per-channel context clear to state A.
- out_valid  out  1  result valid.
- out_z  out  1  Z result.
- out_ch  out  CHW  channel that produced the result.
- out_ready  in  1  downstream accept.
- stat_sel  in  CHW  hit-counter select.
- stat_cnt  out  CNT_W  selected hit count.

Behaviour:
- Engine states use a 2-bit encoding (A=00, B=01, E=10, F=11); no illegal codes exist. Transitions, written as x=1 -> next/Z ; x=0 -> next/Z:
  - A: B/1 ; E/0
  - B: B/0 ; F/0
  - E: F/1 ; A/0
  - F: A/0 ; B/0
- Context store: ctx[NCH] x 2 bits. Reset (reset=0) sets every ctx to A.
- Output reset values: out_valid=0, out_z=0, out_ch=0, stat_cnt=0. The round-robin pointer rr_ptr resets to 0.
- Stall:
  - stall = out_valid & ~out_ready.
  - While stalled, in_ready=0 and the output registers hold their values.
- Arbitration (when not stalled):
  - Eligible set = in_valid & ~ctx_clear.
  - Grant the first eligible channel at or after rr_ptr, searching upward with wrap at NCH-1 -> 0.
  - At most one in_ready bit is high per cycle. With no eligible channel, in_ready=0.
  - On a grant to channel g: rr_ptr <= (g+1) mod NCH. Without a grant, rr_ptr holds.
- Accept cycle (grant to g, bit x):
  - Compute next state and Z from ctx[g] and x using the table above.
  - At the clock edge: ctx[g] <= next, out_valid <= 1, out_z <= Z, out_ch <= g.
  - Latency is 1 cycle from accept to out_valid.
  - Throughput is 1 bit/cycle aggregate when out_ready=1.
- Output register: when out_valid & out_ready and there is no new accept, out_valid <= 0. Accept and drain in the same cycle is allowed (back-to-back).
- ctx_clear[i]: ctx[i] <= A at the next edge and channel i is masked from arbitration that cycle, so clear wins over request. The clear is applied even while stalled.
- Reset asserted mid-operation: immediate return to the reset values. Any in-flight result is discarded.
- Multiple simultaneous requests: served strictly in round-robin order; no channel waits more than NCH-1 grants.

Optional Feature:
Macro FSM_SCHED_STATS_EN.
- Defined:
  - Each channel has a CNT_W-bit saturating counter. It increments on every accepted bit of that channel whose Z=1, and holds at all-ones.
  - ctx_clear[i] zeroes counter i. Reset zeroes all counters.
  - stat_cnt = cnt[stat_sel] (combinational). A stat_sel value >= NCH returns 0.
- Not defined: no counters are built, stat_cnt is tied to 0, and stat_sel is ignored. The port list is identical in both builds.

Test Plan:
- Reset checks: hold reset=0 for 3 cycles, then release -> out_valid=0, in_ready=0 with no requests, all contexts start at A.
- Single-channel sequence: channel 0 only, bits 1,1,0,1,0,0 with out_ready=1 -> out_z = 1,0,0,0,0,0 and states B,B,F,A,E,A; each result 1 cycle after accept, out_ch=0.
- Round-robin: all 4 channels hold in_valid=1 continuously -> grant order 0,1,2,3,0,1,...; each channel's out_z sequence matches an isolated engine fed the same bits.
- Backpressure: out_ready=0 for 5 cycles while requests pend -> in_ready=0, and out_valid/out_z/out_ch hold. After out_ready=1, grants resume from the saved rr_ptr with no lost or duplicated results.
- Clear collision: channel 2 in state E, in_valid[2]=1 and ctx_clear[2]=1 in the same cycle -> no grant to 2 that cycle. The next bit 1 on channel 2 gives out_z=1 with next state B (proves the state is A).
- Stats (with FSM_SCHED_STATS_EN, CNT_W=4): 20 Z=1 events on channel 1 -> stat_cnt=15 (saturated) at stat_sel=1. Pulsing ctx_clear[1] -> stat_cnt=0. Without the macro, stat_cnt=0 throughout.
